// File: rtl/mult_div_hilo_if.sv
// Request/response bundle between the control unit and the multiply/divide unit:
// operands, MTHI/MTLO writes, status and the HI/LO read-back.
interface mult_div_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_hilo.sv
// Multicycle shift-add multiply / restoring divide unit owning the MIPS HI/LO pair.
// Define EARLY_TERM_EN to end multiplies once the remaining multiplier bits are zero.
module mult_div_hilo #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, CALC} state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q, done_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               is_div_q, neg_q, neg_rem_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q, rem_q, quo_q, dvsr_q;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_d, prod_res;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   rem_d, quo_d, quo_res, rem_res;
    logic               last_iter;

    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;

        acc_d     = mplier_q[0] ? acc_q + mcand_q : acc_q;
        // Remainder stays below the divisor, so a non-negative trial fits in WIDTH bits.
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvsr_q};
        rem_d     = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

        prod_res  = neg_q ? -acc_d : acc_d;
        quo_res   = neg_q ? -quo_d : quo_d;
        rem_res   = neg_rem_q ? -rem_d : rem_d;

        last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef EARLY_TERM_EN
        if (!is_div_q && mplier_q[WIDTH-1:1] == '0) begin
            last_iter = 1'b1;
        end
`else
`endif
    end

    // Iteration datapath; contents are don't-care outside CALC, so no reset.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && bus.start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            rem_q    <= '0;
            quo_q    <= a_mag;
            dvsr_q   <= b_mag;
        end else if (state_q == CALC) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            rem_q    <= rem_d;
            quo_q    <= quo_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        is_div_q  <= bus.op[1];
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        dz_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= CALC;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wr_data;
                        if (bus.lo_we) lo_q <= bus.wr_data;
                    end
                end
                CALC: begin
                    if (is_div_q && dvsr_q == '0) begin
                        dz_q    <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (last_iter) begin
                        hi_q    <= is_div_q ? rem_res : prod_res[2*WIDTH-1:WIDTH];
                        lo_q    <= is_div_q ? quo_res : prod_res[WIDTH-1:0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_hilo.sv
// Self-checking bench for mult_div_hilo: directed test-plan cases plus random ops
// compared against an arithmetic reference model of HI/LO, div_zero and latency.
module tb_mult_div_hilo;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_hi = '0, exp_lo = '0;
    logic        exp_dz = 1'b0;
    int          exp_lat = 0;

    always #5 clock = ~clock;

    mult_div_hilo_if #(.WIDTH(32)) bus ();

    mult_div_hilo #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bitlen(input logic [31:0] v);
        int k = 1;
        for (int i = 0; i < 32; i++) if (v[i]) k = i + 1;
        return k;
    endfunction

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    task automatic model_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint          sp, sa, sb, q, r;
        longint unsigned ua, ub, up;
        logic [31:0]     bm;
        exp_dz = 1'b0;
        ua = {32'h0, av};
        ub = {32'h0, bv};
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            2'b00: begin sp = sa * sb; {exp_hi, exp_lo} = sp; end
            2'b01: begin up = ua * ub; {exp_hi, exp_lo} = up; end
            2'b10: if (bv == 0) exp_dz = 1'b1;
                   else begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            default: if (bv == 0) exp_dz = 1'b1;
                   else begin up = ua / ub; exp_lo = up[31:0]; up = ua % ub; exp_hi = up[31:0]; end
        endcase
        if (o[1]) exp_lat = (bv == 0) ? 1 : 32;
        else begin
            bm = (o == 2'b00 && bv[31]) ? -bv : bv;
`ifdef EARLY_TERM_EN
            exp_lat = bitlen(bm);
`else
            exp_lat = 32 + 0 * bitlen(bm);
`endif
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input bit noise, input string tag);
        int          n;
        bit          busy_ok, hold_ok;
        logic [31:0] prev_hi, prev_lo;
        prev_hi = exp_hi;
        prev_lo = exp_lo;
        model_op(o, av, bv);
        @(negedge clock);
        bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
        if (noise) begin bus.hi_we = 1'b1; bus.wr_data = 32'hDEAD_BEEF; end
        @(posedge clock); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0;
        check({tag, " busy@E0"}, bus.busy, 1);
        check({tag, " dz cleared@E0"}, bus.div_zero, 0);
        n = 0; busy_ok = 1; hold_ok = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            @(posedge clock); #1; n++;
            if (noise && n == 3) begin bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'h55; bus.b = 32'h3; end
            if (noise && n == 4) begin bus.start = 1'b0; bus.lo_we = 1'b1; bus.wr_data = 32'hCAFE_F00D; end
            if (noise && n == 5) bus.lo_we = 1'b0;
            if (bus.done !== 1'b1) begin
                if (bus.busy !== 1'b1) busy_ok = 0;
                if (bus.hi !== prev_hi || bus.lo !== prev_lo) hold_ok = 0;
            end
        end
        bus.start = 1'b0; bus.lo_we = 1'b0;
        check({tag, " latency"}, n, exp_lat);
        check({tag, " busy during op"}, busy_ok, 1);
        check({tag, " hilo held"}, hold_ok, 1);
        check({tag, " busy@done"}, bus.busy, 0);
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " lo"}, bus.lo, exp_lo);
        check({tag, " div_zero"}, bus.div_zero, exp_dz);
        @(posedge clock); #1;
        check({tag, " done pulse width"}, bus.done, 0);
    endtask

    task automatic write_hilo(input bit to_hi, input logic [31:0] d);
        @(negedge clock);
        if (to_hi) bus.hi_we = 1'b1; else bus.lo_we = 1'b1;
        bus.wr_data = d;
        @(posedge clock); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        if (to_hi) exp_hi = d; else exp_lo = d;
        check("mthi/mtlo hi", bus.hi, exp_hi);
        check("mthi/mtlo lo", bus.lo, exp_lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;

        repeat (3) @(posedge clock);
        #1;
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset div_zero", bus.div_zero, 0);
        @(negedge clock) reset = 1'b1;

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, "MULT 7*-3");
        check("MULT 7*-3 hi const", bus.hi, 32'hFFFF_FFFF);
        check("MULT 7*-3 lo const", bus.lo, 32'hFFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "MULTU max*max");
        check("MULTU max hi const", bus.hi, 32'hFFFF_FFFE);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "DIV -7/2");
        check("DIV -7/2 lo const", bus.lo, 32'hFFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, 1, "DIVU 100/7");
        write_hilo(1, 32'h1234);
        run_op(2'b11, 32'd100, 32'd0, 0, "DIVU by 0");
        check("DIVU by 0 hi const", bus.hi, 32'h1234);
        run_op(2'b01, 32'd2, 32'd3, 0, "MULTU 2*3");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "DIV overflow");
        run_op(2'b10, 32'd9, 32'd0, 0, "DIV by 0");
        run_op(2'b01, 32'd5, 32'd3, 0, "MULTU 5*3");

        // Reset ten cycles into a MULT: async clear, no done afterwards.
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort hi", bus.hi, 0);
        check("abort lo", bus.lo, 0);
        check("abort busy", bus.busy, 0);
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1;
        end
        check("abort no done", seen, 0);
        run_op(2'b01, 32'd5, 32'd3, 0, "MULTU 5*3 after reset");

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 300));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) write_hilo($urandom_range(0, 1) == 1, $urandom);
            run_op(ro, ra, rb, 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_hilo.md
Name: mult_div_hilo

Overview:
- Parametrised multicycle multiply/divide unit with its own HI/LO register pair, for the MIPS multicycle datapath.
- Serves MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Sits beside the main ALU. Operands come from the A/B registers. HI/LO outputs feed the MemparaReg write-back mux.
- The control unit stalls in a wait state while busy=1.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO (must be ≥4).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request; sampled only in IDLE.
- op  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wr_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  last DIV/DIVU had divisor 0; sticky until next start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE; hi=lo=0; busy=done=div_zero=0; iteration counter=0. Reset mid-operation aborts the operation; no partial result is kept.
- States are IDLE and CALC. Edge E0 is the edge at which start=1 is sampled in IDLE.
- At E0: latch op, |a|, |b| and the result sign bits (signed ops only); clear div_zero; busy←1; state←CALC.
- Multiply: shift-add over the operand magnitudes, one multiplier bit per edge, E1..EW. The 2·WIDTH product is held in internal accumulators.
- Divide: restoring division on magnitudes, one quotient bit per edge, E1..EW.
- At EW:
  - Apply sign correction combinationally.
  - hi←product[2W-1:W] or remainder; lo←product[W-1:0] or quotient.
  - done←1 for exactly one cycle; busy←0; state←IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Overflow case -2^(W-1) / -1: lo=-2^(W-1), hi=0, no flag.
- Divisor 0 (DIV or DIVU): no iterations. At E1: done←1, div_zero←1, busy←0; hi/lo unchanged.
- start while busy is ignored (no queueing).
- start in the cycle where done=1 is accepted, because state is already IDLE.
- hi_we/lo_we:
  - Honoured only in IDLE and when start=0; load wr_data at the next edge.
  - Ignored while busy.
  - If start=1 and a write strobe are both set in IDLE, start wins and the write is dropped.
- hi/lo change only at the result edge, on an MTHI/MTLO write, or on reset. They hold their value while busy, so MFHI/MFLO issued during CALC read the old values.
- All outputs are registered.

Optional Feature:
- Macro EARLY_TERM_EN.
- Defined: for MULT/MULTU, the iteration count equals the bit-length k of |b| (minimum 1). The result edge is E0+k with identical hi/lo values. Divide timing is unchanged. b=0 multiply takes 1 iteration and gives hi=lo=0.
- Undefined: every multiply takes exactly WIDTH iterations.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3), WIDTH=32 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. done high exactly in the cycle after E0+32; busy=1 for 32 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A second start pulse during CALC has no effect on the result or the timing.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=100, b=7 -> lo=14, hi=2.
- Preload hi=0x1234 via hi_we, then DIVU a=100, b=0 -> done and div_zero after E1, hi=0x1234 unchanged. Next MULTU 2*3 clears div_zero at its E0 -> lo=6, hi=0.
- Start MULT, assert reset=0 at cycle 10 -> hi=lo=0, busy=0 immediately (async), no done pulse. A new MULTU 5*3 after release -> lo=15.
- EARLY_TERM_EN defined: MULTU 5*3 -> lo=15, done after E0+2. Undefined: done after E0+32.
